// File: rtl/xt_bus_pkg.sv
// Shared types and default widths for the per-master bus front end.
package xt_bus_pkg;

  localparam int XT_ADDR_WIDTH = 32;
  localparam int XT_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    RESP = 2'd3
  } bus_port_state_e;

  typedef struct packed {
    logic                         write;
    logic [XT_ADDR_WIDTH-1:0]     addr;
    logic [XT_DATA_WIDTH-1:0]     wdata;
    logic [XT_DATA_WIDTH/8-1:0]   wstrb;
  } xt_cmd_t;

endpackage

// File: rtl/xt_bus_master_port.sv
// Per-master front end: holds one command, requests the arbiter, strobes the
// shared bus while granted and returns a single-cycle response or timeout error.
module xt_bus_master_port
  import xt_bus_pkg::*;
#(
  parameter int ADDR_WIDTH     = XT_ADDR_WIDTH,
  parameter int DATA_WIDTH     = XT_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    read_req,
  output logic                    write_req,
  input  logic                    read_grant,
  input  logic                    write_grant,
  output logic                    bus_re,
  output logic                    bus_we,
  output logic [ADDR_WIDTH-1:0]   bus_addr,
  output logic [DATA_WIDTH-1:0]   bus_wdata,
  output logic [DATA_WIDTH/8-1:0] bus_wstrb,
  input  logic                    bus_ack,
  input  logic [DATA_WIDTH-1:0]   bus_rdata,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef struct packed {
    logic                    write;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
  } cmd_t;

  bus_port_state_e  state;
  cmd_t             cmd_q;
  logic [CNT_W-1:0] cnt;
  logic             grant;
  logic             timeout;
  logic             busy;

  assign grant   = cmd_q.write ? write_grant : read_grant;
  assign timeout = (cnt == CNT_LAST);
  assign busy    = (state == REQ) || (state == XFER);

  // Outputs decode only from state and the latch, so reset drops them at once.
  assign cmd_ready = (state == IDLE);
  assign read_req  = busy && !cmd_q.write;
  assign write_req = busy && cmd_q.write;
  assign bus_re    = (state == XFER) && !cmd_q.write;
  assign bus_we    = (state == XFER) && cmd_q.write;
  assign rsp_valid = (state == RESP);
  assign bus_addr  = cmd_q.addr;
  assign bus_wdata = cmd_q.wdata;
  assign bus_wstrb = cmd_q.wstrb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cmd_q     <= '0;
      cnt       <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            cmd_q.write <= cmd_write;
            cmd_q.addr  <= cmd_addr;
            cmd_q.wdata <= cmd_wdata;
            cmd_q.wstrb <= cmd_wstrb;
            cnt         <= '0;
            state       <= REQ;
          end
        end
        REQ: begin
          if (timeout) begin
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            state     <= RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (grant) state <= XFER;
          end
        end
        XFER: begin
          // An ack on the timeout cycle still completes normally.
          if (bus_ack) begin
            rsp_err   <= 1'b0;
            rsp_rdata <= cmd_q.write ? '0 : bus_rdata;
            state     <= RESP;
          end else if (timeout) begin
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            state     <= RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (!grant) state <= REQ;
          end
        end
        RESP: begin
          rsp_err <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
